// File: rtl/vend_controller.sv
// Vending machine controller: item select, coin collection, dispense and greedy change return.
// Optional inactivity refund in COLLECT is compiled in when VC_TIMEOUT_EN is defined.
module vend_controller #(
  parameter int CREDIT_W    = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [3:0]          sel_price,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  output logic                ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                coin_reject
);

  // state   | meaning
  // IDLE    | waiting for an item selection
  // COLLECT | accumulating coins toward the latched price
  // VEND    | release item, compute change
  // CHANGE  | return change one coin per cycle, largest first
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  localparam logic [1:0] COIN_1   = 2'b00;
  localparam logic [1:0] COIN_2   = 2'b01;
  localparam logic [1:0] COIN_5   = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  function automatic logic [CREDIT_W-1:0] coin_amount(input logic [1:0] code);
    case (code)
      COIN_1:  return CREDIT_W'(1);
      COIN_2:  return CREDIT_W'(2);
      COIN_5:  return CREDIT_W'(5);
      default: return '0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            price_q, price_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CREDIT_W-1:0]   change_q, change_d;
  logic                  ready_q, ready_d;
  logic                  dispense_q, dispense_d;
  logic                  change_valid_q, change_valid_d;
  logic [1:0]            change_coin_q, change_coin_d;
  logic                  coin_reject_q, coin_reject_d;

  logic                  coin_ok;
  logic                  timeout_hit;
  logic [CREDIT_W-1:0]   price_ext;
  logic [CREDIT_W-1:0]   sum;
  logic [CREDIT_W-1:0]   vend_change;

  assign coin_ok     = coin_valid && (coin_val != COIN_BAD);
  assign price_ext   = CREDIT_W'(price_q);
  assign sum         = credit_q + coin_amount(coin_val);
  assign vend_change = credit_q - price_ext;

`ifdef VC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Down-counter reloads on COLLECT entry and on every accepted coin.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != S_COLLECT || coin_ok) begin
      tmo_d = TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_COLLECT) && (tmo_q == '0) && !coin_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= TMO_LOAD;
    else     tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    price_d        = price_q;
    credit_d       = credit_q;
    change_d       = change_q;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    change_coin_d  = 2'b00;
    coin_reject_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        coin_reject_d = coin_valid;
        if (sel_valid && sel_price != 4'd0) begin
          price_d  = sel_price;
          credit_d = '0;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel || timeout_hit) begin
          coin_reject_d = coin_valid;
          change_d      = credit_q;
          credit_d      = '0;
          state_d       = (credit_q == '0) ? S_IDLE : S_CHANGE;
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = sum;
            if (sum >= price_ext) state_d = S_VEND;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        coin_reject_d = coin_valid;
        dispense_d    = 1'b1;
        change_d      = vend_change;
        credit_d      = '0;
        state_d       = (vend_change == '0) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        coin_reject_d  = coin_valid;
        change_valid_d = 1'b1;
        if (change_q >= CREDIT_W'(5))      change_coin_d = COIN_5;
        else if (change_q >= CREDIT_W'(2)) change_coin_d = COIN_2;
        else                               change_coin_d = COIN_1;
        change_d = change_q - coin_amount(change_coin_d);
        if (change_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      price_q        <= '0;
      credit_q       <= '0;
      change_q       <= '0;
      ready_q        <= 1'b1;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'b00;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      price_q        <= price_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      ready_q        <= ready_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign ready        = ready_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;

endmodule
